// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
//   - FSM state encoding (IDLE, GUARD, SHOW)
//   - all-off constants for anodes and cathodes
//   - 16-entry hex-to-segment table, active-low {g,f,e,d,c,b,a}
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to 7-segment decoder.
// Ports:
//   nibble   - 4-bit hex value
//   segments - active-low segment pattern {g,f,e,d,c,b,a}
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner. Every rising edge of the slow tick_clk
// square wave (sampled in the clk_in domain, never used as a clock) advances to
// the next digit. data/dp_in/blank_mask are snapshotted at frame start so a frame
// never mixes old and new values.
// Optional feature macro: SEG7_GHOST_BLANK_EN - inserts a GUARD_CYCLES all-off
// interval after every advance to suppress ghosting.
// Ports:
//   clk_in     - system clock
//   reset      - asynchronous, active-high
//   tick_clk   - scan strobe square wave, asynchronous to clk_in
//   data       - 8 hex nibbles, digit k = data[4k+3:4k]
//   dp_in      - decimal point request per digit, active-high
//   blank_mask - 1 keeps digit k dark
//   anode      - digit enables, active-low
//   cathode    - segments {g,f,e,d,c,b,a}, active-low
//   dp_n       - decimal point, active-low
//   digit_sel  - index of the digit being driven
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        tick_clk,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_mask,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp_n,
    output logic [2:0]  digit_sel
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || GUARD_CYCLES < 1 || GUARD_CYCLES > 255)
    begin : g_param_check
        $error("seg7_scan_ctrl: parameter out of range");
    end

`ifdef SEG7_GHOST_BLANK_EN
    localparam state_t     ENTRY_STATE = GUARD;
    localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES - 1);
`else
    localparam state_t     ENTRY_STATE = SHOW;
`endif

    // tick_clk synchronizer and rising-edge detect
    logic s1, s2, prev, adv;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= tick_clk;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign adv = s2 & ~prev;

    // Scan state
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        load, idx_last;
    logic [31:0] data_q;
    logic [7:0]  dp_q, blank_q;

    assign idx_last = (idx_q == 3'(NUM_DIGITS - 1));

`ifdef SEG7_GHOST_BLANK_EN
    logic [7:0] guard_q, guard_d;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) guard_q <= '0;
        else       guard_q <= guard_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
`ifdef SEG7_GHOST_BLANK_EN
        guard_d = guard_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (adv) begin
                    idx_d = '0;
                    load  = 1'b1;
                end
            end
`ifdef SEG7_GHOST_BLANK_EN
            SHOW, GUARD: begin
`else
            SHOW: begin
`endif
                if (adv) begin
                    if (idx_last) begin
                        idx_d = '0;
                        load  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
`ifdef SEG7_GHOST_BLANK_EN
                else if (state_q == GUARD) begin
                    if (guard_q == '0) state_d = SHOW;
                    else               guard_d = guard_q - 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // Every advance (including leaving IDLE) enters the entry state; an advance
        // during GUARD restarts the guard count.
        if (adv) begin
            state_d = ENTRY_STATE;
`ifdef SEG7_GHOST_BLANK_EN
            guard_d = GUARD_LOAD;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                data_q  <= data;
                dp_q    <= dp_in;
                blank_q <= blank_mask;
            end
        end
    end

    // Registered outputs
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;
    logic       in_range;
    logic [7:0] anode_d;
    logic [6:0] cathode_d;
    logic       dp_n_d;

    assign cur_nibble = data_q[{idx_q, 2'b00} +: 4];
    assign in_range   = ({29'd0, idx_q} < NUM_DIGITS);

    seg7_hex_decode u_hex_decode (
        .nibble   (cur_nibble),
        .segments (cur_seg)
    );

    always_comb begin
        anode_d   = AN_OFF;
        cathode_d = SEG_OFF;
        dp_n_d    = 1'b1;
        if (state_q == SHOW) begin
            cathode_d = cur_seg;
            dp_n_d    = ~dp_q[idx_q];
            if (in_range && !blank_q[idx_q]) anode_d = ~(8'd1 << idx_q);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            anode     <= AN_OFF;
            cathode   <= SEG_OFF;
            dp_n      <= 1'b1;
            digit_sel <= '0;
        end else begin
            anode     <= anode_d;
            cathode   <= cathode_d;
            dp_n      <= dp_n_d;
            digit_sel <= idx_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios with literal
// expectations, then randomized tick/data/reset stimulus against a digit-level model.
module tb_seg7_scan_ctrl;

    localparam int unsigned NUM_DIGITS   = 8;
    localparam int unsigned GUARD_CYCLES = 16;
`ifdef SEG7_GHOST_BLANK_EN
    localparam int LAT = 4 + GUARD_CYCLES;
`else
    localparam int LAT = 4;
`endif

    logic        clk_in = 1'b0;
    logic        reset;
    logic        tick_clk;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  blank_mask;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp_n;
    logic [2:0]  digit_sel;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_clk   (tick_clk),
        .data       (data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .anode      (anode),
        .cathode    (cathode),
        .dp_n       (dp_n),
        .digit_sel  (digit_sel)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Digit-level model: which digit of which snapshot is on display
    bit          m_active;
    int          m_idx;
    logic [31:0] m_data;
    logic [7:0]  m_dp, m_blank;
    bit          m_last_tick;
    bit          m_rise_q[$];
    int          m_guard;

    logic [7:0] exp_anode;
    logic [6:0] exp_cathode;
    logic       exp_dp_n;
    logic [2:0] exp_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active    = 1'b0;
        m_idx       = 0;
        m_data      = '0;
        m_dp        = '0;
        m_blank     = '0;
        m_last_tick = 1'b0;
        m_rise_q.delete();
        m_guard     = 0;
        exp_anode   = 8'hFF;
        exp_cathode = 7'h7F;
        exp_dp_n    = 1'b1;
        exp_sel     = 3'd0;
    endfunction

    function automatic void model_outputs();
        if (!m_active || m_guard > 0) begin
            exp_anode   = 8'hFF;
            exp_cathode = 7'h7F;
            exp_dp_n    = 1'b1;
        end else begin
            exp_anode   = (m_blank[m_idx] || m_idx >= int'(NUM_DIGITS)) ? 8'hFF
                                                                       : 8'(255 - (1 << m_idx));
            exp_cathode = hex_tab[(m_data >> (4 * m_idx)) & 32'hF];
            exp_dp_n    = ~m_dp[m_idx];
        end
        exp_sel = 3'(m_idx);
    endfunction

    function automatic void model_adv();
        if (!m_active || m_idx == int'(NUM_DIGITS) - 1) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_data   = data;
            m_dp     = dp_in;
            m_blank  = blank_mask;
        end else begin
            m_idx++;
        end
`ifdef SEG7_GHOST_BLANK_EN
        m_guard = GUARD_CYCLES;
`endif
    endfunction

    // A tick rising edge sampled at edge n moves the digit at edge n+2; the
    // display reflects the digit one edge after that.
    function automatic void model_edge();
        bit rise;
        if (reset) return;
        model_outputs();
        if (m_guard > 0) m_guard--;
        if (m_rise_q.size() == 2) begin
            rise = m_rise_q.pop_front();
            if (rise) model_adv();
        end
        m_rise_q.push_back(tick_clk && !m_last_tick);
        m_last_tick = tick_clk;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            model_edge();
            #3;
        end
    endtask

    // One scan advance; returns once the new digit is on the outputs
    task automatic advance();
        tick_clk = 1'b1;
        step(LAT);
        tick_clk = 1'b0;
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("cyc_anode", anode, exp_anode);
            chk("cyc_cathode", cathode, exp_cathode);
            chk("cyc_dp_n", dp_n, exp_dp_n);
            chk("cyc_digit_sel", digit_sel, exp_sel);
        end
    end

    logic [7:0] an_lit  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] cat_lit [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    initial begin
        int hold;
        reset      = 1'b1;
        tick_clk   = 1'b0;
        data       = '0;
        dp_in      = '0;
        blank_mask = '0;
        model_reset();

        // Reset state and idle with tick low
        step(5);
        chk("rst_anode", anode, 8'hFF);
        chk("rst_cathode", cathode, 7'h7F);
        chk("rst_dp_n", dp_n, 1'b1);
        chk("rst_digit_sel", digit_sel, 3'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        step(50);
        chk("idle_anode", anode, 8'hFF);

        // First edge: latency and digit 0
        data  = 32'h89AB_CDEF;
        dp_in = 8'h01;
        tick_clk = 1'b1;
        step(LAT - 1);
        chk("lat_early_anode", anode, 8'hFF);
        step(1);
        tick_clk = 1'b0;
        chk("first_anode", anode, 8'hFE);
        chk("first_cathode", cathode, 7'h0E);
        chk("first_dp_n", dp_n, 1'b0);
        step(10);

        // Walk the frame; new data mid-frame must not leak in
        for (int k = 1; k < 8; k++) begin
            advance();
            chk("frame_anode", anode, an_lit[k]);
            chk("frame_cathode", cathode, cat_lit[k]);
            if (k == 3) data = 32'h1234_5678;
            if (k == 5) blank_mask = 8'h80;
            step(10);
        end

        // Wrap: new snapshot, digit 0 = 8
        advance();
        chk("wrap_anode", anode, 8'hFE);
        chk("wrap_cathode", cathode, 7'h00);
        step(10);
        for (int k = 1; k < 8; k++) begin
            advance();
            step(5);
        end
        chk("blank_anode", anode, 8'hFF);
        chk("blank_digit_sel", digit_sel, 3'd7);

        // Reset at idx 5
        for (int k = 0; k < 6; k++) begin
            advance();
            step(5);
        end
        chk("pre_rst_sel", digit_sel, 3'd5);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_anode", anode, 8'hFF);
        chk("async_rst_sel", digit_sel, 3'd0);
        step(2);
        reset = 1'b0;
        data  = 32'h0000_0003;
        dp_in = 8'h00;
        step(5);
        advance();
        chk("post_rst_anode", anode, 8'hFE);
        chk("post_rst_cathode", cathode, 7'h30);
        chk("post_rst_dp_n", dp_n, 1'b1);
        step(10);

        // Randomized phase
        hold = 0;
        repeat (4000) begin
            if (hold == 0) begin
                tick_clk = ~tick_clk;
                hold = $urandom_range(1, 30);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 39) == 0) data = $urandom;
            if ($urandom_range(0, 39) == 0) dp_in = 8'($urandom);
            if ($urandom_range(0, 39) == 0) blank_mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                model_reset();
                step($urandom_range(1, 3));
                reset = 1'b0;
            end
            step(1);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
